// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the MEM-stage data memory responder.
//   - RV32I load/store funct3 encodings (F3_LB..F3_LHU)
//   - mem_state_e : responder FSM states
//   - mem_size_e  : access width decoded from funct3
//   - f3_size()   : funct3 -> access width (undefined encodings behave as word)
//   - byte_en()   : byte write-enable mask for a width and byte lane
package riscv_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } mem_size_e;

  function automatic mem_size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: return SZ_B;
      F3_LH, F3_LHU: return SZ_H;
      default:       return SZ_W;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input mem_size_e sz, input logic [1:0] lane);
    case (sz)
      SZ_B:    return 4'b0001 << lane;
      SZ_H:    return 4'b0011 << {lane[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32-bit synchronous data array with per-byte write enables.
// Read is registered (read-before-write on the same address).
// Contents are not reset.
// Ports:
//   clk    in   clock
//   we     in   write strobe
//   be     in   4-bit byte enable, bit n covers wdata[8n+7:8n]
//   addr   in   word index
//   wdata  in   write data (already lane-replicated)
//   rdata  out  registered read data of addr
module dmem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we && be[b]) begin
        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder. Accepts one RV32I load/store, holds the
// pipeline with `stall` for a fixed latency, commits the access, then pulses
// resp_valid for one cycle with the extended load data.
// Optional feature macro: MISALIGN_TRAP_EN
//   defined     : misaligned H/W accesses are suppressed, rdata=0, misalign_err
//                 pulses with resp_valid
//   not defined : misalign_err tied low, misaligned accesses are aligned down
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   req_valid    in   request present (sampled in IDLE only)
//   req_we       in   1 = store, 0 = load
//   req_funct3   in   RV32I funct3 (B/H/W/BU/HU; others behave as W)
//   req_addr     in   byte address; bits above the array index are ignored
//   req_wdata    in   store data, right-aligned
//   stall        out  freeze upstream pipeline registers
//   resp_valid   out  one-cycle response pulse
//   rdata        out  extended load data (0 for stores)
//   misalign_err out  misaligned access flag (RESP cycle only)
module data_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        misalign_err
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  mem_state_e       state_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic             we_p0;
  logic [2:0]       funct3_p0;
  logic [AW+1:0]    addr_p0;
  logic [31:0]      wdata_p0;

  mem_size_e        size_p0;
  logic [1:0]       lane_p0;
  logic             trap_p0;
  logic             commit;
  logic             accept;
  logic [AW-1:0]    arr_addr;
  logic             arr_we;
  logic [3:0]       arr_be;
  logic [31:0]      arr_wdata;
  logic [31:0]      arr_rdata;
  logic [31:0]      load_data;

  // Address bits above the array index wrap around and are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:AW+2];

  function automatic logic [31:0] extend_load(input logic [2:0]  f3,
                                              input logic [1:0]  lane,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_LB:   return {{24{b[7]}}, b};
      F3_LBU:  return {24'b0, b};
      F3_LH:   return {{16{h[15]}}, h};
      F3_LHU:  return {16'b0, h};
      default: return word;
    endcase
  endfunction

  assign size_p0 = f3_size(funct3_p0);

  // Lane is taken aligned to the access width, so a misaligned access
  // without the trap simply lands on the aligned-down location.
  always_comb begin
    lane_p0 = 2'b00;
    case (size_p0)
      SZ_B:    lane_p0 = addr_p0[1:0];
      SZ_H:    lane_p0 = {addr_p0[1], 1'b0};
      default: lane_p0 = 2'b00;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign trap_p0 = ((size_p0 == SZ_H) && addr_p0[0]) ||
                   ((size_p0 == SZ_W) && (addr_p0[1:0] != 2'b00));
`else
  assign trap_p0 = 1'b0;
`endif

  assign accept = (state_p0 == IDLE) && req_valid;
  assign commit = (state_p0 == BUSY) && (cnt_p0 == '0);
  assign stall  = accept || (state_p0 == BUSY);

  // In IDLE the array is addressed straight from the request so the word is
  // already registered by the first BUSY cycle (needed when LATENCY == 1).
  assign arr_addr = (state_p0 == IDLE) ? req_addr[AW+1:2] : addr_p0[AW+1:2];
  assign arr_we   = commit && we_p0 && !trap_p0;
  assign arr_be   = byte_en(size_p0, lane_p0);

  always_comb begin
    arr_wdata = wdata_p0;
    case (size_p0)
      SZ_B:    arr_wdata = {4{wdata_p0[7:0]}};
      SZ_H:    arr_wdata = {2{wdata_p0[15:0]}};
      default: arr_wdata = wdata_p0;
    endcase
  end

  assign load_data = (we_p0 || trap_p0) ? 32'h0 : extend_load(funct3_p0, lane_p0, arr_rdata);

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .be    (arr_be),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  // p0: request capture, latency count and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0     <= IDLE;
      cnt_p0       <= '0;
      we_p0        <= 1'b0;
      funct3_p0    <= 3'b000;
      addr_p0      <= '0;
      wdata_p0     <= 32'h0;
      resp_valid   <= 1'b0;
      rdata        <= 32'h0;
      misalign_err <= 1'b0;
    end else begin
      case (state_p0)
        IDLE: begin
          if (req_valid) begin
            we_p0     <= req_we;
            funct3_p0 <= req_funct3;
            addr_p0   <= req_addr[AW+1:0];
            wdata_p0  <= req_wdata;
            cnt_p0    <= CNT_W'(LATENCY - 1);
            state_p0  <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_p0 != '0) begin
            cnt_p0 <= cnt_p0 - CNT_W'(1);
          end else begin
            rdata        <= load_data;
            misalign_err <= trap_p0;
            resp_valid   <= 1'b1;
            state_p0     <= RESP;
          end
        end
        RESP: begin
          resp_valid   <= 1'b0;
          misalign_err <= 1'b0;
          state_p0     <= IDLE;
        end
        default: state_p0 <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;
  localparam int NBYTES  = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        stall;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        misalign_err;

  int checks = 0;
  int failures = 0;

  // Byte-addressed reference memory.
  logic [7:0] mem_b [NBYTES];

  data_mem_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .resp_valid   (resp_valid),
    .rdata        (rdata),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  // Reference: apply one access to the byte model, return expected rdata / error.
  task automatic model_apply(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, output logic [31:0] exp_rd,
                             output logic exp_err);
    int nb;
    int base;
    logic [31:0] val;
    nb = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    base = int'(addr % 32'(NBYTES));
    exp_err = 1'b0;
    exp_rd  = 32'h0;
`ifdef MISALIGN_TRAP_EN
    if ((base % nb) != 0) begin
      exp_err = 1'b1;
      return;
    end
`endif
    base = base - (base % nb);
    if (we) begin
      for (int i = 0; i < nb; i++) mem_b[base + i] = wd[8*i +: 8];
    end else begin
      val = 32'h0;
      for (int i = 0; i < nb; i++) val = val | (32'(mem_b[base + i]) << (8 * i));
      if ((f3 == 3'd0 || f3 == 3'd1) && val >= (32'd1 << (8 * nb - 1)))
        val = val - (32'd1 << (8 * nb));
      exp_rd = val;
    end
  endtask

  // Drive one request from IDLE (caller is just after a rising edge) and
  // collect what the DUT returned. Ends one cycle after RESP.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic err,
                        output int lat, output logic stall_ok, output logic [31:0] rd_after,
                        output logic err_after);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    #1;
    stall_ok = (stall === 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 50) begin
      if (stall !== 1'b1) stall_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    rd  = rdata;
    err = misalign_err;
    if (stall !== 1'b0) stall_ok = 1'b0;
    @(posedge clk); #1;
    rd_after  = rdata;
    err_after = misalign_err;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b expected 0", stall); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL reset_misalign: got %b expected 0", misalign_err); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic        t_we [12]  = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
    logic [2:0]  t_f3 [12]  = '{3'd2, 3'd2, 3'd0, 3'd4, 3'd1, 3'd0, 3'd2, 3'd2, 3'd5, 3'd1, 3'd1, 3'd0};
    logic [31:0] t_ad [12]  = '{32'h10, 32'h10, 32'h13, 32'h13, 32'h12, 32'h11, 32'h10,
                               32'h10 + NBYTES, 32'h12, 32'h12, 32'h12, 32'h10};
    logic [31:0] t_wd [12]  = '{32'hDEADBEEF, 0, 0, 0, 0, 32'h55, 0, 0, 0, 32'h8001, 0, 0};
    logic [31:0] t_ex [12]  = '{32'h0, 32'hDEADBEEF, 32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD,
                               32'h0, 32'hDEAD55EF, 32'hDEAD55EF, 32'h0000DEAD, 32'h0,
                               32'hFFFF8001, 32'hFFFFFFEF};
    logic [31:0] rd, rd_after, exp_rd;
    logic err, err_after, stall_ok, exp_err;
    int lat;
    for (int i = 0; i < 12; i++) begin
      model_apply(t_we[i], t_f3[i], t_ad[i], t_wd[i], exp_rd, exp_err);
      do_req(t_we[i], t_f3[i], t_ad[i], t_wd[i], rd, err, lat, stall_ok, rd_after, err_after);
      checks++; if (rd !== t_ex[i]) begin failures++; $display("FAIL directed_rdata[%0d]: got %h expected %h", i, rd, t_ex[i]); end
      checks++; if (lat != LATENCY + 1) begin failures++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, LATENCY + 1); end
      checks++; if (stall_ok !== 1'b1) begin failures++; $display("FAIL directed_stall[%0d]: got %b expected 1", i, stall_ok); end
      checks++; if (rd_after !== t_ex[i]) begin failures++; $display("FAIL directed_rdata_hold[%0d]: got %h expected %h", i, rd_after, t_ex[i]); end
    end
  endtask

  task automatic test_misalign();
    logic [31:0] rd, rd_after, exp_rd, exp_wrd;
    logic err, err_after, stall_ok, exp_err;
    int lat;
    model_apply(1'b0, 3'd2, 32'h11, 32'h0, exp_rd, exp_err);
    do_req(1'b0, 3'd2, 32'h11, 32'h0, rd, err, lat, stall_ok, rd_after, err_after);
`ifdef MISALIGN_TRAP_EN
    exp_wrd = 32'h0;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL misalign_err: got %b expected 1", err); end
`else
    exp_wrd = 32'h800155EF;
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL misalign_err: got %b expected 0", err); end
`endif
    checks++; if (rd !== exp_wrd) begin failures++; $display("FAIL misalign_rdata: got %h expected %h", rd, exp_wrd); end
    checks++; if (err_after !== 1'b0) begin failures++; $display("FAIL misalign_err_pulse: got %b expected 0", err_after); end
    // Misaligned word store, then read back the aligned word.
    model_apply(1'b1, 3'd2, 32'h12, 32'hFFFFFFFF, exp_rd, exp_err);
    do_req(1'b1, 3'd2, 32'h12, 32'hFFFFFFFF, rd, err, lat, stall_ok, rd_after, err_after);
    checks++; if (err !== exp_err) begin failures++; $display("FAIL misalign_store_err: got %b expected %b", err, exp_err); end
    model_apply(1'b0, 3'd2, 32'h10, 32'h0, exp_rd, exp_err);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, rd, err, lat, stall_ok, rd_after, err_after);
    checks++; if (rd !== exp_rd) begin failures++; $display("FAIL misalign_store_effect: got %h expected %h", rd, exp_rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, rd_after, exp_rd;
    logic err, err_after, stall_ok, exp_err;
    int lat;
    model_apply(1'b1, 3'd2, 32'h20, 32'hCAFEF00D, exp_rd, exp_err);
    do_req(1'b1, 3'd2, 32'h20, 32'hCAFEF00D, rd, err, lat, stall_ok, rd_after, err_after);
    do_req(1'b0, 3'd2, 32'h20, 32'h0, rd, err, lat, stall_ok, rd_after, err_after);
    checks++; if (rd !== 32'hCAFEF00D) begin failures++; $display("FAIL rstmid_preload: got %h expected cafef00d", rd); end
    // Store of 1 aborted by reset while BUSY; model is not updated.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'h1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rstmid_stall: got %b expected 0", stall); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rstmid_resp_valid: got %b expected 0", resp_valid); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL rstmid_rdata: got %h expected 0", rdata); end
    checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL rstmid_misalign: got %b expected 0", misalign_err); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_req(1'b0, 3'd2, 32'h20, 32'h0, rd, err, lat, stall_ok, rd_after, err_after);
    checks++; if (rd !== 32'hCAFEF00D) begin failures++; $display("FAIL rstmid_no_write: got %h expected cafef00d", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, rd_after, exp_rd;
    logic err, err_after, stall_ok, exp_err;
    int lat;
    model_apply(1'b0, 3'd2, 32'h10, 32'h0, exp_rd, exp_err);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10; req_wdata = 32'h0;
    @(posedge clk); #1;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
    checks++; if (rdata !== exp_rd) begin failures++; $display("FAIL b2b_first_rdata: got %h expected %h", rdata, exp_rd); end
    // Next request already waiting during RESP: must be ignored until IDLE.
    req_we = 1'b1; req_addr = 32'h14; req_wdata = 32'h12345678;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL b2b_resp_stall: got %b expected 0", stall); end
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle_resp_valid: got %b expected 0", resp_valid); end
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL b2b_idle_stall: got %b expected 1", stall); end
    model_apply(1'b1, 3'd2, 32'h14, 32'h12345678, exp_rd, exp_err);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
    checks++; if (lat != LATENCY + 1) begin failures++; $display("FAIL b2b_second_latency: got %0d expected %0d", lat, LATENCY + 1); end
    @(posedge clk); #1;
    model_apply(1'b0, 3'd2, 32'h14, 32'h0, exp_rd, exp_err);
    do_req(1'b0, 3'd2, 32'h14, 32'h0, rd, err, lat, stall_ok, rd_after, err_after);
    checks++; if (rd !== exp_rd) begin failures++; $display("FAIL b2b_second_store: got %h expected %h", rd, exp_rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, rd_after, exp_rd, addr, wd;
    logic err, err_after, stall_ok, exp_err, we;
    logic [2:0] f3;
    int lat;
    // Fill a 64-byte window so every random load has defined data.
    for (int w = 0; w < 16; w++) begin
      wd = $urandom;
      model_apply(1'b1, 3'd2, 32'(w * 4), wd, exp_rd, exp_err);
      do_req(1'b1, 3'd2, 32'(w * 4), wd, rd, err, lat, stall_ok, rd_after, err_after);
    end
    for (int n = 0; n < 80; n++) begin
      we   = 1'($urandom_range(0, 2) == 0);
      f3   = 3'($urandom_range(0, 7));
      addr = ($urandom & ~32'(NBYTES - 1)) | 32'($urandom_range(0, 63));
      wd   = $urandom;
      model_apply(we, f3, addr, wd, exp_rd, exp_err);
      do_req(we, f3, addr, wd, rd, err, lat, stall_ok, rd_after, err_after);
      checks++; if (rd !== exp_rd) begin failures++; $display("FAIL rand_rdata[%0d] we=%b f3=%0d addr=%h: got %h expected %h", n, we, f3, addr, rd, exp_rd); end
      checks++; if (err !== exp_err) begin failures++; $display("FAIL rand_misalign[%0d] f3=%0d addr=%h: got %b expected %b", n, f3, addr, err, exp_err); end
      checks++; if (lat != LATENCY + 1) begin failures++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", n, lat, LATENCY + 1); end
      checks++; if (stall_ok !== 1'b1) begin failures++; $display("FAIL rand_stall[%0d]: got %b expected 1", n, stall_ok); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_misalign();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
